// File: rtl/motor_pkg.sv
// Shared encodings for the N-channel H-bridge motor driver.
package motor_pkg;

    // H-bridge {IN1,IN2} pin encodings
    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_REV   = 2'b01;
    localparam logic [1:0] DIR_COAST = 2'b00;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    // Per-channel controller states
    typedef enum logic [1:0] {
        ST_COAST = 2'd0,
        ST_RUN   = 2'd1,
        ST_DEAD  = 2'd2,
        ST_BRAKE = 2'd3
    } ch_state_t;

endpackage

// File: rtl/motor_ch_ctrl.sv
// One motor channel: target conditioning, soft ramp, reversal dead-time,
// hard brake, PWM compare and registered pin outputs.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   COAST  | bridge floating, duty 0; leaves as soon as a nonzero target
//   RUN    | driving in cur_dir, duty ramps toward goal
//   DEAD   | duty reached 0 on a reversal; coast for DEAD_TICKS ticks
//   BRAKE  | both low-side on, enable held high, duty cleared
module motor_ch_ctrl
    import motor_pkg::*;
#(
    parameter int DUTY_W     = 10,
    parameter int DUTY_MAX   = (1 << DUTY_W) - 1,
    parameter int RAMP_STEP  = 8,
    parameter int DEAD_TICKS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              brake,
    input  logic [DUTY_W:0]   target,
    input  logic [DUTY_W-1:0] pwm_cnt,
    input  logic              ramp_tick,
    output logic              pwm,
    output logic [1:0]        dir_in,
    output logic              settled
);

    localparam int              DW        = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [DUTY_W:0] STEP      = (DUTY_W+1)'(RAMP_STEP);
    localparam logic [DUTY_W:0] MAX_W     = (DUTY_W+1)'(DUTY_MAX);
    localparam logic [DW-1:0]   DEAD_LOAD = DW'(DEAD_TICKS - 1);

    ch_state_t         state, state_nxt;
    logic [DUTY_W-1:0] duty_cur, duty_nxt;
    logic              cur_dir, dir_nxt;   // 1 = forward
    logic [DW-1:0]     dead_cnt, dead_nxt;

    logic              sgn;
    logic [DUTY_W:0]   abs_t;
    logic [DUTY_W-1:0] mag;
    logic              rev;
    logic [DUTY_W-1:0] goal;
    logic [DUTY_W:0]   up, dn;
    logic [DUTY_W-1:0] ramped;

    // Effective target: magnitude saturated to DUTY_MAX (so -2^DUTY_W fits), zeroed when disabled
    always_comb begin
        sgn   = ~target[DUTY_W];
        abs_t = target[DUTY_W] ? -target : target;
        mag   = '0;
        if (en) begin
            mag = (abs_t > MAX_W) ? MAX_W[DUTY_W-1:0] : abs_t[DUTY_W-1:0];
        end
    end

    // One ramp step toward goal, clipped at goal; guard bit catches wrap in either direction
    always_comb begin
        rev    = (mag != '0) && (sgn != cur_dir);
        goal   = rev ? '0 : mag;
        up     = {1'b0, duty_cur} + STEP;
        dn     = {1'b0, duty_cur} - STEP;
        ramped = duty_cur;
        if (duty_cur < goal) begin
            ramped = (up > {1'b0, goal}) ? goal : up[DUTY_W-1:0];
        end else if (duty_cur > goal) begin
            ramped = (dn[DUTY_W] || (dn < {1'b0, goal})) ? goal : dn[DUTY_W-1:0];
        end
    end

    // Next-state logic; brake overrides every state in the same cycle
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty_cur;
        dir_nxt   = cur_dir;
        dead_nxt  = dead_cnt;
        if (brake) begin
            state_nxt = ST_BRAKE;
            duty_nxt  = '0;
        end else begin
            case (state)
                ST_COAST: begin
                    duty_nxt = '0;
                    if (mag != '0) begin
                        dir_nxt   = sgn;
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ramp_tick) duty_nxt = ramped;
                    if (duty_cur == '0 && rev) begin
                        state_nxt = ST_DEAD;
                        dead_nxt  = DEAD_LOAD;
                    end else if (duty_cur == '0 && mag == '0) begin
                        state_nxt = ST_COAST;
                    end
                end
                ST_DEAD: begin
                    duty_nxt = '0;
                    if (ramp_tick) begin
                        if (dead_cnt == '0) state_nxt = ST_COAST;
                        else                dead_nxt  = dead_cnt - 1'b1;
                    end
                end
                ST_BRAKE: begin
                    duty_nxt  = '0;
                    state_nxt = ST_COAST;
                end
                default: begin
                    state_nxt = ST_COAST;
                    duty_nxt  = '0;
                end
            endcase
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_COAST;
            duty_cur <= '0;
            cur_dir  <= 1'b0;
            dead_cnt <= '0;
        end else begin
            state    <= state_nxt;
            duty_cur <= duty_nxt;
            cur_dir  <= dir_nxt;
            dead_cnt <= dead_nxt;
        end
    end

    // Registered pin outputs, one cycle behind the channel state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm     <= 1'b0;
            dir_in  <= DIR_COAST;
            settled <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    pwm    <= (pwm_cnt < duty_cur);
                    dir_in <= cur_dir ? DIR_FWD : DIR_REV;
                end
                ST_BRAKE: begin
                    pwm    <= 1'b1;
                    dir_in <= DIR_BRAKE;
                end
                default: begin
                    pwm    <= 1'b0;
                    dir_in <= DIR_COAST;
                end
            endcase
            settled <= ((state == ST_RUN) && (sgn == cur_dir) && (duty_cur == mag)) ||
                       ((state == ST_COAST) && (mag == '0));
        end
    end

endmodule

// File: rtl/motor_ramp_drv.sv
// N-channel soft-ramp H-bridge driver: shared PWM/ramp timebase plus one
// controller per channel.
module motor_ramp_drv
    import motor_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int DUTY_W     = 10,
    parameter int DUTY_MAX   = (1 << DUTY_W) - 1,
    parameter int PWM_PRESC  = 4,
    parameter int RAMP_DIV   = 16,
    parameter int RAMP_STEP  = 8,
    parameter int DEAD_TICKS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_CH-1:0]            brake,
    input  logic [N_CH*(DUTY_W+1)-1:0] target,
    output logic [N_CH-1:0]            pwm,
    output logic [2*N_CH-1:0]          dir_in,
    output logic [N_CH-1:0]            settled
);

    localparam int PW = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [PW-1:0]     presc_cnt;
    logic [DUTY_W-1:0] pwm_cnt;
    logic [RW-1:0]     ramp_cnt;
    logic              presc_wrap;
    logic              ramp_tick;

    assign presc_wrap = (presc_cnt == PW'(PWM_PRESC - 1));
    assign ramp_tick  = (ramp_cnt == RW'(RAMP_DIV - 1));

    // PWM timebase: prescaler feeding a free-running period counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (presc_wrap) begin
            presc_cnt <= '0;
            pwm_cnt   <= pwm_cnt + 1'b1;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // Ramp timebase: one-cycle tick every RAMP_DIV clocks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           ramp_cnt <= '0;
        else if (ramp_tick) ramp_cnt <= '0;
        else                ramp_cnt <= ramp_cnt + 1'b1;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        motor_ch_ctrl #(
            .DUTY_W     (DUTY_W),
            .DUTY_MAX   (DUTY_MAX),
            .RAMP_STEP  (RAMP_STEP),
            .DEAD_TICKS (DEAD_TICKS)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .brake     (brake[i]),
            .target    (target[i*(DUTY_W+1) +: DUTY_W+1]),
            .pwm_cnt   (pwm_cnt),
            .ramp_tick (ramp_tick),
            .pwm       (pwm[i]),
            .dir_in    (dir_in[2*i +: 2]),
            .settled   (settled[i])
        );
    end

endmodule

// File: tb/tb_motor_ramp_drv.sv
// Self-checking bench for motor_ramp_drv with default parameters.
module tb_motor_ramp_drv;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [1:0]        brake;
    logic signed [10:0] t0, t1;
    logic [21:0]       target;
    logic [1:0]        pwm;
    logic [3:0]        dir_in;
    logic [1:0]        settled;

    int n_chk  = 0;
    int n_fail = 0;

    assign target = {t1, t0};

    always #5 clk = ~clk;

    motor_ramp_drv u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .brake   (brake),
        .target  (target),
        .pwm     (pwm),
        .dir_in  (dir_in),
        .settled (settled)
    );

    typedef struct {
        logic       en;
        logic [1:0] brk;
        int         t0;
        int         t1;
        logic [3:0] dir;
        logic [1:0] stl;
        int         hi0;
        int         hi1;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Counts clock cycles until settled[ch] rises (bounded by budget)
    task automatic wait_settled(input int ch, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (settled[ch] && n > 2) break;
        end
    endtask

    // High cycles of each pwm over one full PWM period (1024 counts x 4 clocks)
    task automatic measure(output int h0, output int h1);
        h0 = 0;
        h1 = 0;
        repeat (4096) begin
            @(negedge clk);
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
        end
    endtask

    initial begin
        int n, h0, h1;

        vecs[0] = '{1'b1, 2'b00,  200,    0, 4'b0010, 2'b11,  800,    0};
        vecs[1] = '{1'b1, 2'b00,  200, -300, 4'b0110, 2'b11,  800, 1200};
        vecs[2] = '{1'b1, 2'b00, -100, -300, 4'b0101, 2'b11,  400, 1200};
        vecs[3] = '{1'b0, 2'b00, -100, -300, 4'b0000, 2'b11,    0,    0};
        vecs[4] = '{1'b1, 2'b00, -100, -300, 4'b0101, 2'b11,  400, 1200};
        vecs[5] = '{1'b1, 2'b01, -100, -300, 4'b0111, 2'b10, 4096, 1200};
        vecs[6] = '{1'b1, 2'b00, -100, -300, 4'b0101, 2'b11,  400, 1200};
        vecs[7] = '{1'b1, 2'b00,    0,  500, 4'b1000, 2'b11,    0, 2000};

        rst = 1'b0; en = 1'b0; brake = 2'b00; t0 = '0; t1 = '0;
        repeat (3) @(negedge clk);
        check("reset_pwm", int'(pwm), 0);
        check("reset_dir", int'(dir_in), 0);
        check("reset_settled", int'(settled), 0);

        // Soft start ch0 to +200
        en = 1'b1; t0 = 11'sd200; rst = 1'b1;
        repeat (2) @(negedge clk);
        check("soft_dir", int'(dir_in[1:0]), 2);
        wait_settled(0, 1000, n);
        check_rng("soft_settle_cycles", n + 2, 380, 420);
        measure(h0, h1);
        check("soft_pwm_hi", h0, 800);

        // Reversal +200 -> -100
        t0 = -11'sd100;
        n = 0;
        while (dir_in[1:0] == 2'b10 && n < 1000) begin @(negedge clk); n++; end
        check_rng("rev_fwd_hold", n, 380, 420);
        n = 0;
        while (dir_in[1:0] == 2'b00 && n < 200) begin @(negedge clk); n++; end
        check_rng("rev_dead_len", n, 62, 66);
        check("rev_dir_after", int'(dir_in[1:0]), 1);
        wait_settled(0, 600, n);
        check_rng("rev_settle_cycles", n, 192, 224);

        // Brake ch1 mid-ramp (duty ~80 of 160), then release
        t1 = 11'sd160;
        repeat (165) @(negedge clk);
        brake = 2'b10;
        repeat (2) @(negedge clk);
        check("brake_dir", int'(dir_in[3:2]), 3);
        h1 = 0;
        repeat (20) begin @(negedge clk); h1 += int'(pwm[1]); end
        check("brake_pwm_hi", h1, 20);
        brake = 2'b00;
        repeat (2) @(negedge clk);
        check("brake_release_coast", int'(dir_in[3:2]), 0);
        wait_settled(1, 1000, n);
        check_rng("brake_reramp_cycles", n, 288, 368);

        // Async reset mid-run, then restart toward +40
        t0 = 11'sd40; t1 = '0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("areset_pwm", int'(pwm), 0);
        check("areset_dir", int'(dir_in), 0);
        check("areset_settled", int'(settled), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_settled(0, 500, n);
        check_rng("areset_reramp_cycles", n, 70, 95);

        // Saturation: -1024 -> reverse at duty 1023
        t0 = -11'sd1024;
        wait_settled(0, 3000, n);
        check("sat_dir", int'(dir_in[1:0]), 1);
        measure(h0, h1);
        check("sat_pwm_hi", h0, 4092);

        // Table vectors from a clean reset
        rst = 1'b0; en = 1'b0; t0 = '0; t1 = '0; brake = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            en = vecs[i].en;
            brake = vecs[i].brk;
            t0 = 11'(vecs[i].t0);
            t1 = 11'(vecs[i].t1);
            repeat (2600) @(negedge clk);
            check($sformatf("vec%0d_dir", i), int'(dir_in), int'(vecs[i].dir));
            check($sformatf("vec%0d_settled", i), int'(settled), int'(vecs[i].stl));
            measure(h0, h1);
            check($sformatf("vec%0d_pwm0_hi", i), h0, vecs[i].hi0);
            check($sformatf("vec%0d_pwm1_hi", i), h1, vecs[i].hi1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_ramp_drv.md
Name: motor_ramp_drv

Overview:
- Parametrised N-channel DC-motor driver for the car's H-bridge (IN1/IN2 + enable PWM per channel); successor to the fixed two-motor, mode-driven controller.
- Takes a signed speed target per channel and produces the PWM enable plus direction pins.
- Adds soft-start/stop ramping, a dead-time coast on direction reversal, a hard brake, and per-channel settled status.
- Sits between the tracking/decision FSM and the board pins. clk is 100 MHz.

Parameters:
- N_CH, 2, number of motor channels.
- DUTY_W, 10, duty/PWM counter width; PWM period = 2^DUTY_W counts.
- DUTY_MAX, 2^DUTY_W-1, saturation ceiling for duty magnitude.
- PWM_PRESC, 4, clk cycles per PWM count (≥1).
- RAMP_DIV, 16, clk cycles per ramp tick (≥1).
- RAMP_STEP, 8, duty change per ramp tick (≥1).
- DEAD_TICKS, 4, ramp ticks spent coasting on reversal (≥1).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; low forces effective target 0 on all channels (graceful ramp-down).
- brake  in  N_CH  per-channel hard brake request.
- target  in  N_CH*(DUTY_W+1)  packed signed two's-complement speed; channel i at bits [i*(DUTY_W+1) +: DUTY_W+1]; positive = forward.
- pwm  out  N_CH  H-bridge enable PWM per channel.
- dir_in  out  2*N_CH  channel i at [2i+1:2i] = {IN1,IN2}: 10 forward, 01 reverse, 00 coast, 11 brake.
- settled  out  N_CH  channel has reached its effective target and is stable.

Behaviour:
- Reset (rst=0, async): pwm=0, dir_in=0, settled=0; all counters 0; every channel in COAST with duty_cur=0. Reset mid-operation aborts ramps immediately; nothing resumes from the old duty.
- Shared timing:
  - Prescaler counts 0..PWM_PRESC-1. At wrap, pwm_cnt (DUTY_W bits) increments, wrapping modulo 2^DUTY_W.
  - Separate ramp counter 0..RAMP_DIV-1 produces a one-cycle ramp_tick at wrap.
- Effective target: mag = |target| saturated to DUTY_MAX; -2^DUTY_W saturates to DUTY_MAX. sgn = sign of target. If en=0, mag=0.
- Ramp (on ramp_tick only):
  - If duty_cur < goal: duty_cur = min(duty_cur+RAMP_STEP, goal).
  - If duty_cur > goal: duty_cur = max(duty_cur-RAMP_STEP, goal).
  - No overflow or underflow; compute with one guard bit.
- Per-channel FSM, states COAST, RUN, DEAD, BRAKE:
  - COAST: dir 00, duty_cur=0. If mag≠0, latch cur_dir=sgn → RUN.
  - RUN: dir = cur_dir.
    - If sgn==cur_dir, goal=mag.
    - Otherwise (reversal), goal=0; when duty_cur reaches 0 → DEAD.
    - If mag==0 and duty_cur==0 → COAST.
  - DEAD: dir 00, duty 0. Counts DEAD_TICKS ramp ticks, then → COAST, which picks up the new direction on the next cycle.
  - BRAKE: entered from any state when brake[i]=1 (highest priority, same cycle). dir 11, pwm forced 1, duty_cur cleared to 0. When brake[i]=0 → COAST.
- Outputs are registered, with 1-cycle latency from internal state.
  - pwm[i] = (pwm_cnt < duty_cur), or 1 in BRAKE.
  - duty_cur = DUTY_MAX gives pwm high for 2^DUTY_W-1 of 2^DUTY_W counts; 100% duty exists only in BRAKE.
  - settled[i] = 1 when in RUN with sgn==cur_dir and duty_cur==mag, or in COAST with mag==0.
- A target change mid-ramp takes effect at the next ramp tick. Channels are fully independent apart from the shared ticks.

Decomposition:
- Package motor_pkg holds:
  - dir encoding constants DIR_FWD=2'b10, DIR_REV=2'b01, DIR_COAST=2'b00, DIR_BRAKE=2'b11.
  - channel state encoding.
- Sub-module motor_ch_ctrl holds one channel's FSM, ramp, duty compare and output registers. The top holds the prescaler, pwm_cnt and ramp counter, and uses generate to instantiate N_CH channels.

Test Plan (defaults unless noted):
- Soft start: en=1, ch0 target=+200 → dir_in[1:0]=10 within 2 cycles; duty steps +8 per 16 cycles; settled[0]=1 after 25 ticks (~400 cycles); pwm[0] high 200 of every 1024 PWM counts.
- Reversal: ch0 +200 settled → target -100 → duty ramps to 0 (25 ticks, dir stays 10), then dir 00 for 4 ticks (64 cycles), then 01. Ramp 0→100 takes 13 ticks, the last step clipped 96→100; settled then 1.
- Brake mid-ramp: ch1 at duty 80, brake[1]=1 → next cycle dir 11, pwm[1]=1; release → COAST; reaccelerates from 0 toward the held target.
- Saturation, DUTY_W=8: target -256 → dir 01; duty settles at 255; pwm high 255 of 256 counts, never 256.
- Async reset mid-run: pull rst low between clock edges → pwm, dir_in, settled become 0 immediately. Release with target +40 held → ramp restarts from 0 (5 ticks).
- en low with both channels running → both ramp to 0 independently, dir 00, settled=1; en high again → both re-ramp to their targets.
